// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer: valid/ready handshake, flush, bubble insertion,
// optional 2-entry skid with registered ready, and a saturating stall counter.
module pipe_stage_buf #(
  parameter int unsigned       DATA_W  = 64,
  parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{1'b0}},
  parameter bit                SKID    = 1'b1,
  parameter int unsigned       CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [1:0]        o_count
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e            stateQ, stateD;
  logic [DATA_W-1:0] mainQ, mainD;
  logic [DATA_W-1:0] skidQ, skidD;
  logic              readyQ;
  logic [CNT_W-1:0]  stallQ;
  logic              upXfer, dnXfer;

  // Skid mode exposes a registered ready; single-register mode lets a draining
  // consumer admit a new payload in the same cycle.
  always_comb begin
    if (SKID) begin
      o_ready = readyQ;
    end else begin
      o_ready = i_ready | (stateQ == StEmpty);
    end
  end

  assign o_valid     = (stateQ != StEmpty);
  assign o_data      = mainQ;
  assign o_stall_cnt = stallQ;
  assign upXfer      = i_valid & o_ready;
  assign dnXfer      = o_valid & i_ready;

  always_comb begin
    o_count = 2'd0;
    case (stateQ)
      StOne:   o_count = 2'd1;
      StFull:  o_count = 2'd2;
      default: o_count = 2'd0;
    endcase
  end

  always_comb begin
    stateD = stateQ;
    mainD  = mainQ;
    skidD  = skidQ;
    if (flush) begin
      stateD = StEmpty;
      mainD  = NOP_VAL;
      skidD  = NOP_VAL;
    end else begin
      case (stateQ)
        StEmpty: begin
          if (upXfer) begin
            mainD  = i_data;
            stateD = StOne;
          end
        end
        StOne: begin
          // Upstream without downstream only happens with SKID=1 (ready is registered).
          if (upXfer && dnXfer) begin
            mainD = i_data;
          end else if (upXfer) begin
            skidD  = i_data;
            stateD = StFull;
          end else if (dnXfer) begin
            mainD  = NOP_VAL;
            stateD = StEmpty;
          end
        end
        StFull: begin
          if (dnXfer) begin
            mainD  = skidQ;
            skidD  = NOP_VAL;
            stateD = StOne;
          end
        end
        default: begin
          stateD = StEmpty;
          mainD  = NOP_VAL;
          skidD  = NOP_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= StEmpty;
      mainQ  <= NOP_VAL;
      skidQ  <= NOP_VAL;
      readyQ <= 1'b1;
      stallQ <= '0;
    end else begin
      stateQ <= stateD;
      mainQ  <= mainD;
      skidQ  <= skidD;
      readyQ <= (stateD != StFull);
      if (o_valid && !i_ready && (stallQ != {CNT_W{1'b1}})) begin
        stallQ <= stallQ + CntOne;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: skid instance and single-register instance (4-bit counter)
// checked every cycle against a queue-based reference plus directed literal checks.
module tb_pipe_stage_buf;

  localparam logic [15:0] NopA = 16'hDEAD;
  localparam logic [15:0] NopB = 16'h0000;

  logic clk = 1'b0;
  logic rst;

  logic        vA, rA, fA, orA, ovA;
  logic [15:0] dA, odA, scA;
  logic [1:0]  ocA;

  logic        vB, rB, fB, orB, ovB;
  logic [15:0] dB, odB;
  logic [3:0]  scB;
  logic [1:0]  ocB;

  int nCmp = 0;
  int nBad = 0;
  bit chkEn = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(16), .NOP_VAL(NopA), .SKID(1'b1), .CNT_W(16)) dutA (
    .clk(clk), .rst(rst), .flush(fA), .i_valid(vA), .o_ready(orA), .i_data(dA),
    .o_valid(ovA), .i_ready(rA), .o_data(odA), .o_stall_cnt(scA), .o_count(ocA)
  );

  pipe_stage_buf #(.DATA_W(16), .NOP_VAL(NopB), .SKID(1'b0), .CNT_W(4)) dutB (
    .clk(clk), .rst(rst), .flush(fB), .i_valid(vB), .o_ready(orB), .i_data(dB),
    .o_valid(ovB), .i_ready(rB), .o_data(odB), .o_stall_cnt(scB), .o_count(ocB)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: each buffer is a FIFO of held payloads.
  logic [15:0] qA[$];
  logic [15:0] qB[$];
  int cA = 0;
  int cB = 0;
  int szA, szB;
  bit upA, upB, dnA, dnB;

  always @(posedge clk) begin
    szA = qA.size();
    szB = qB.size();
    upA = vA && (szA < 2);
    dnA = (szA > 0) && rA;
    upB = vB && (rB || (szB == 0));
    dnB = (szB > 0) && rB;
    if (rst) begin
      qA.delete();
      qB.delete();
      cA = 0;
      cB = 0;
    end else begin
      if (szA > 0 && !rA && cA < 65535) cA++;
      if (szB > 0 && !rB && cB < 15) cB++;
      if (fA) qA.delete();
      else begin
        if (dnA) void'(qA.pop_front());
        if (upA) qA.push_back(dA);
      end
      if (fB) qB.delete();
      else begin
        if (dnB) void'(qB.pop_front());
        if (upB) qB.push_back(dB);
      end
    end
  end

  always @(negedge clk) begin
    if (chkEn) begin
      check("A.valid", ovA, qA.size() > 0);
      check("A.data", odA, (qA.size() > 0) ? qA[0] : NopA);
      check("A.count", ocA, qA.size());
      check("A.ready", orA, qA.size() < 2);
      check("A.stall", scA, cA);
      check("B.valid", ovB, qB.size() > 0);
      check("B.data", odB, (qB.size() > 0) ? qB[0] : NopB);
      check("B.count", ocB, qB.size());
      check("B.ready", orB, rB || (qB.size() == 0));
      check("B.stall", scB, cB);
    end
  end

  task automatic toPos();
    @(posedge clk);
    #1;
  endtask

  task automatic toNeg();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    vA = 1'b1; dA = 16'hAAAA; rA = 1'b1; fA = 1'b0;
    vB = 1'b1; dB = 16'hAAAA; rB = 1'b1; fB = 1'b0;
    toPos();
    chkEn = 1'b1;
    toPos();
    rst = 1'b0; vA = 1'b0; vB = 1'b0;
    toNeg();
    check("rst.A.valid", ovA, 0);
    check("rst.A.data", odA, 16'hDEAD);
    check("rst.A.count", ocA, 0);
    check("rst.A.stall", scA, 0);
    check("rst.A.ready", orA, 1);
    check("rst.B.valid", ovB, 0);

    // Streaming through the skid buffer.
    for (int i = 1; i <= 4; i++) begin
      toPos();
      vA = 1'b1; dA = 16'(i);
      toNeg();
      if (i > 1) check("stream.data", odA, i - 1);
    end
    toPos();
    vA = 1'b0;
    toNeg();
    check("stream.last", odA, 4);
    check("stream.stall", scA, 0);
    toPos();

    // Skid fill and drain.
    rA = 1'b0; vA = 1'b1; dA = 16'd5;
    toPos();
    dA = 16'd6;
    toPos();
    dA = 16'd7;
    toNeg();
    check("fill.data", odA, 5);
    check("fill.count", ocA, 2);
    check("fill.ready", orA, 0);
    toPos();
    toPos();
    rA = 1'b1;
    toNeg();
    check("fill.stall", scA, 3);
    toPos();
    toNeg();
    check("drain.6", odA, 6);
    toPos();
    vA = 1'b0;
    toNeg();
    check("drain.7", odA, 7);
    toPos();
    toNeg();
    check("drain.empty", ovA, 0);
    toPos();

    // Flush while full.
    rA = 1'b0; vA = 1'b1; dA = 16'd8;
    toPos();
    dA = 16'd9;
    toPos();
    fA = 1'b1; rA = 1'b1; dA = 16'd10;
    toNeg();
    check("flush.pre.count", ocA, 2);
    toPos();
    fA = 1'b0; vA = 1'b0;
    toNeg();
    check("flush.valid", ovA, 0);
    check("flush.data", odA, 16'hDEAD);
    check("flush.count", ocA, 0);
    check("flush.stall", scA, 4);
    toPos();
    toNeg();
    check("flush.dropped", ovA, 0);
    toPos();

    // Single-register mode with toggling i_ready.
    vB = 1'b1; dB = 16'd11; rB = 1'b1;
    toPos();
    dB = 16'd12; rB = 1'b0;
    toNeg();
    check("s0.data11", odB, 11);
    check("s0.ready0", orB, 0);
    toPos();
    rB = 1'b1;
    toNeg();
    check("s0.hold11", odB, 11);
    check("s0.ready1", orB, 1);
    toPos();
    dB = 16'd13;
    toNeg();
    check("s0.data12", odB, 12);
    toPos();
    vB = 1'b0;
    toNeg();
    check("s0.data13", odB, 13);
    toPos();

    // Counter saturation on the 4-bit counter.
    vB = 1'b1; dB = 16'h0055; rB = 1'b0;
    repeat (22) toPos();
    toNeg();
    check("sat.15", scB, 15);
    toPos();
    toNeg();
    check("sat.hold", scB, 15);
    toPos();
    vB = 1'b0; rB = 1'b1;
    toPos();

    // Randomised traffic on both instances.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      vA  = $urandom_range(0, 1) == 1;
      rA  = $urandom_range(0, 3) != 0;
      fA  = $urandom_range(0, 15) == 0;
      dA  = 16'($urandom);
      vB  = $urandom_range(0, 1) == 1;
      rB  = $urandom_range(0, 1) == 1;
      fB  = $urandom_range(0, 15) == 0;
      dB  = 16'($urandom);
      toPos();
    end
    rst = 1'b0;
    toNeg();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
